// File: rtl/shift_reg_unload.sv
// Parallel-in, serial-out unload of a timestep history bus.
// Streams one word per valid/ready transfer, newest-first by default.
module shift_reg_unload #(
  parameter int NUM_ITERATIONS = 68,
  parameter int WIDTH          = 32,
  parameter int IDXW           = 7,
  parameter bit REVERSE        = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [NUM_ITERATIONS*WIDTH-1:0] i,
  output logic                            busy,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [WIDTH-1:0]                o,
  output logic [IDXW-1:0]                 idx,
  output logic                            last,
  output logic                            done
);

  localparam int BW = NUM_ITERATIONS * WIDTH;
  localparam logic [IDXW-1:0] TOP = IDXW'(NUM_ITERATIONS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    busy    = 1'b0;
    o_valid = 1'b0;
    o       = '0;
    idx     = '0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          buf_d   = i;
          cnt_d   = TOP;
          idx_d   = REVERSE ? TOP : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        o       = REVERSE ? buf_q[BW-1 -: WIDTH]
                          : buf_q[WIDTH-1:0];
        idx     = idx_q;
        last    = (cnt_q == '0);
        if (o_ready) begin
          // head word leaves; vacated slot fills with zero
          buf_d = REVERSE ? (buf_q << WIDTH)
                          : (buf_q >> WIDTH);
          cnt_d = cnt_q - 1'b1;
          idx_d = REVERSE ? idx_q - 1'b1
                          : idx_q + 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_unload.sv
// Bench for shift_reg_unload: both stream orders run side by side,
// each checked by a queue-based reference model at the falling edge.
module tb_shift_reg_unload;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic           load;
  logic           o_ready;
  logic [N*W-1:0] i;

  logic          busy_s  [2];
  logic          ov_s    [2];
  logic [W-1:0]  o_s     [2];
  logic [IW-1:0] idx_s   [2];
  logic          last_s  [2];
  logic          done_s  [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input int inst, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL rev=%0d %s t=%0t actual=%0h required=%0h",
               inst, nm, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar r = 0; r < 2; r++) begin : g_dut
    shift_reg_unload #(
      .NUM_ITERATIONS(N),
      .WIDTH(W),
      .IDXW(IW),
      .REVERSE(r != 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .i(i),
      .busy(busy_s[r]),
      .o_valid(ov_s[r]),
      .o_ready(o_ready),
      .o(o_s[r]),
      .idx(idx_s[r]),
      .last(last_s[r]),
      .done(done_s[r])
    );

    // Reference: an accepted load queues the words in emit order.
    logic [W-1:0]  qw[$];
    logic [IW-1:0] qi[$];
    bit            exp_done = 1'b0;

    always @(negedge clk) begin
      bit v;
      bit nd;
      int w;
      if (!rst) begin
        qw.delete();
        qi.delete();
        exp_done = 1'b0;
        chk(r, "rst_valid", 32'(ov_s[r]), 32'd0);
        chk(r, "rst_o", 32'(o_s[r]), 32'd0);
        chk(r, "rst_done", 32'(done_s[r]), 32'd0);
      end else begin
        v = (qw.size() != 0);
        chk(r, "valid", 32'(ov_s[r]), 32'(v));
        chk(r, "busy", 32'(busy_s[r]), 32'(v));
        chk(r, "done", 32'(done_s[r]), 32'(exp_done));
        if (v) begin
          chk(r, "o", 32'(o_s[r]), 32'(qw[0]));
          chk(r, "idx", 32'(idx_s[r]), 32'(qi[0]));
          chk(r, "last", 32'(last_s[r]), 32'(qw.size() == 1));
        end else begin
          chk(r, "idle_o", 32'(o_s[r]), 32'd0);
          chk(r, "idle_idx", 32'(idx_s[r]), 32'd0);
          chk(r, "idle_last", 32'(last_s[r]), 32'd0);
        end
        nd = 1'b0;
        if (v && o_ready) begin
          void'(qw.pop_front());
          void'(qi.pop_front());
          nd = (qw.size() == 0);
        end
        if (load && !v) begin
          for (int k = 0; k < N; k++) begin
            w = (r != 0) ? N - 1 - k : k;
            qw.push_back(i[w*W +: W]);
            qi.push_back(IW'(w));
          end
        end
        exp_done = nd;
      end
    end
  end

  task automatic cyc(input logic ld, input logic rdy,
                     input logic [N*W-1:0] b);
    load    = ld;
    o_ready = rdy;
    i       = b;
    @(posedge clk);
    #1;
  endtask

  localparam logic [N*W-1:0] A = 32'h44332211;
  localparam logic [N*W-1:0] B = 32'hDDCCBBAA;
  localparam logic [N*W-1:0] S = 32'h8055AA7F;

  initial begin
    rst     = 1'b0;
    load    = 1'b0;
    o_ready = 1'b0;
    i       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 1, '0);

    // plain streams, both orders
    cyc(1, 1, A);
    repeat (6) cyc(0, 1, A);

    // backpressure in cycles 2-3
    cyc(1, 1, A);
    cyc(0, 1, A);
    cyc(0, 0, A);
    cyc(0, 0, A);
    repeat (5) cyc(0, 1, A);

    // loads while busy, then in the done cycle
    cyc(1, 1, A);
    cyc(0, 1, A);
    cyc(1, 1, B);
    cyc(0, 1, A);
    cyc(1, 1, B);
    cyc(1, 1, B);
    repeat (6) cyc(0, 1, '0);

    // signed extremes
    cyc(1, 1, S);
    repeat (6) cyc(0, 1, S);

    // asynchronous reset mid-stream
    cyc(1, 1, A);
    cyc(0, 1, A);
    #2;
    rst = 1'b0;
    #1;
    for (int r = 0; r < 2; r++) begin
      chk(r, "async_valid", 32'(ov_s[r]), 32'd0);
      chk(r, "async_busy", 32'(busy_s[r]), 32'd0);
      chk(r, "async_o", 32'(o_s[r]), 32'd0);
      chk(r, "async_idx", 32'(idx_s[r]), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc(0, 1, A);
    rst = 1'b1;
    cyc(0, 1, A);
    cyc(1, 1, A);
    repeat (6) cyc(0, 1, A);

    // random traffic with a changing bus
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0),
          N*W'($urandom));
    end
    repeat (8) cyc(0, 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_unload.md
Name: shift_reg_unload

Overview:
- Parallel-in, serial-out counterpart of the per-timestep capture shift register in the LSTM datapath.
- It takes a full NUM_ITERATIONS×WIDTH history bus in one cycle and streams it out one word per transfer under a valid/ready handshake.
- Default order is newest-first (REVERSE=1), which feeds backpropagation-through-time in the dnnbp backward pass.
- Word k of the bus is bits [(k+1)*WIDTH-1 : k*WIDTH]. Word 0 is the oldest timestep; word NUM_ITERATIONS-1 is the newest.

Parameters:
NUM_ITERATIONS, 68, number of timestep words held (≥2)
WIDTH, 32, bits per signed word
IDXW, 7, index width; must satisfy 2^IDXW ≥ NUM_ITERATIONS
REVERSE, 1, 1 = emit word NUM_ITERATIONS-1 first (newest-first); 0 = emit word 0 first

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
load  input  1  capture i and start a stream; honoured only when busy=0
i  input  NUM_ITERATIONS*WIDTH  signed parallel history bus
busy  output  1  1 from the cycle after an accepted load until the final transfer
o_valid  output  1  o/idx/last are valid
o_ready  input  1  downstream accepts this cycle
o  output  WIDTH  signed current word
idx  output  IDXW  timestep index of the current word
last  output  1  current word is the final one of the stream
done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; internal buffer=0; counter=0; busy=0, o_valid=0, o=0, idx=0, last=0, done=0.
- States: IDLE and RUN.
- IDLE:
  - busy=0, o_valid=0, o=0, idx=0, last=0.
  - load=1 at a clock edge: latch i into the buffer, load the counter with NUM_ITERATIONS-1, go to RUN.
  - Latency is 1 cycle: o_valid=1 with the first word in the cycle after load.
- RUN:
  - busy=1, o_valid=1.
  - o is the head word: top word if REVERSE=1, word 0 if REVERSE=0.
  - idx is NUM_ITERATIONS-1 counting down if REVERSE=1; 0 counting up if REVERSE=0.
  - last=1 when the counter is 0.
- Transfer: o_valid & o_ready at a clock edge.
  - On a transfer, shift the buffer by WIDTH toward the head, zero-filling the vacated word.
  - Decrement the counter and step idx.
- Backpressure (o_ready=0): o, idx and last hold stable; no state change.
- Final transfer (last & o_ready): next cycle state=IDLE, o_valid=0, busy=0, done=1 for exactly that one cycle.
- load while busy=1 is ignored, including in the same cycle as the final transfer. A new load is accepted at the earliest in the done cycle, so back-to-back streams have a one-cycle gap.
- o is a raw bit copy of the word: no sign extension, no arithmetic, signed value preserved.
- If rst is asserted mid-stream, the stream aborts immediately and all outputs return to reset values. done is not pulsed.
- Changes on i after the load edge have no effect on the stream in progress.

Test Plan:
Override NUM_ITERATIONS=4, WIDTH=8, IDXW=2. Load i={8'h44,8'h33,8'h22,8'h11} (word0=0x11) in every scenario.
1. REVERSE=1, o_ready=1 constantly, load at cycle 0:
   - cycles 1–4: o=44,33,22,11 with idx=3,2,1,0; last=1 only in cycle 4.
   - cycle 5: done=1, busy=0, o_valid=0, o=0.
2. REVERSE=0, same stimulus:
   - cycles 1–4: o=11,22,33,44 with idx=0,1,2,3.
   - cycle 5: done=1.
3. Backpressure, REVERSE=1: o_ready=0 in cycles 2–3, 1 otherwise.
   - o=33, idx=2 held through cycles 2–4.
   - Stream completes with o=11 in cycle 6; done=1 in cycle 7.
4. Load while busy, REVERSE=1: second load with a different bus in cycles 2 and 4 (the final-transfer cycle).
   - Both loads are ignored; the output sequence is unchanged (44,33,22,11).
   - A load in done cycle 5 is accepted; its first word appears in cycle 6.
5. Signed data, REVERSE=1: word3=8'h80, word0=8'h7F.
   - o=8'h80 in cycle 1 and o=8'h7F in cycle 4, bit-exact.
6. Reset mid-stream: drive rst=0 asynchronously between edges in cycle 2.
   - Outputs go to 0 immediately; no done pulse follows.
   - After release, a fresh load streams correctly from idx=3.
